// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability counter,
// filtered level and one-cycle press/release strobes. Define LONG_PRESS_EN for long_press.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 100000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] button_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
`ifdef LONG_PRESS_EN
  ,
  output logic [N_CH-1:0] long_press
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_multi: STABLE_CYCLES must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("debounce_multi: HOLD_CYCLES must be at least 1");
  end

  logic [N_CH-1:0]  sync_r [SYNC_STAGES];
  logic [N_CH-1:0]  sync_q;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
    end else begin
      sync_r[0] <= button_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // A channel flips on the edge its counter has already seen STABLE_CYCLES-1 differing samples.
  always_comb begin
    upd = '0;
    for (int i = 0; i < N_CH; i++) begin
      upd[i] = (sync_q[i] != button_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      button_out <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (sync_q[i] == button_out[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          cnt[i]        <= '0;
          button_out[i] <= sync_q[i];
          rise_pulse[i] <= sync_q[i];
          fall_pulse[i] <= ~sync_q[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt [N_CH];

  // The hold count clears on the release edge itself so long_press drops with button_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) hold_cnt[i] <= '0;
      long_press <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!button_out[i] || upd[i]) begin
          hold_cnt[i]   <= '0;
          long_press[i] <= 1'b0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          if (hold_cnt[i] == HOLD_LAST) long_press[i] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios with literal expectations,
// then randomized bouncing and resets against a sample-window reference model.
module tb_debounce_multi;
  localparam int N_CH   = 4;
  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int HOLD   = 64;
  localparam int DEPTH  = SYNC + STABLE;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] button_in = '1;
  logic [N_CH-1:0] button_out, rise_pulse, fall_pulse;
`ifdef LONG_PRESS_EN
  logic [N_CH-1:0] long_press;
`endif

  debounce_multi #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in), .button_out(button_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
`ifdef LONG_PRESS_EN
    , .long_press(long_press)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: hist[k] is the raw input sampled k edges ago. The counter at an edge
  // sees the sample taken SYNC edges earlier; the output flips once the STABLE most recent
  // such samples all differ from it.
  logic [N_CH-1:0] hist [DEPTH];
  logic [N_CH-1:0] m_out = '0, m_rise = '0, m_fall = '0, m_long = '0;
  int rise_t [N_CH];

  always @(posedge clk) begin
    cyc++;
    m_rise = '0;
    m_fall = '0;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) hist[k] = '0;
      m_out  = '0;
      m_long = '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = button_in;
      for (int ch = 0; ch < N_CH; ch++) begin
        bit all_new;
        all_new = 1'b1;
        for (int k = SYNC; k < DEPTH; k++) if (hist[k][ch] == m_out[ch]) all_new = 1'b0;
        if (all_new) begin
          m_out[ch] = ~m_out[ch];
          if (m_out[ch]) begin
            m_rise[ch] = 1'b1;
            rise_t[ch] = cyc;
          end else begin
            m_fall[ch] = 1'b1;
          end
        end
        m_long[ch] = m_out[ch] && ((cyc - rise_t[ch]) >= HOLD);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("button_out", 32'(button_out), 32'(m_out));
      check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
      check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
`ifdef LONG_PRESS_EN
      check("long_press", 32'(long_press), 32'(m_long));
`endif
    end
  end

  initial begin
    logic saw, msaw;
    int rem [N_CH];
    logic [N_CH-1:0] lvl;
    int rst_left;

    // 1: reset held with all buttons pressed
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 1) check("t1_first_edge", 32'({button_out, rise_pulse, fall_pulse}), 32'h0);
      if (e == 17) check("t1_e17_out", 32'(button_out), 32'h0);
      if (e == 18) begin
        check("t1_e18_out", 32'(button_out), 32'hF);
        check("t1_e18_rise", 32'(rise_pulse), 32'hF);
        check("t1_model_e18", 32'(m_out), 32'hF);
      end
      if (e == 19) check("t1_e19_rise", 32'(rise_pulse), 32'h0);
    end
    button_in = '0;
    repeat (25) @(negedge clk);

    // 2: ch0 bouncing 5 high / 5 low
    saw = 1'b0;
    msaw = 1'b0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        button_in = (c < 5) ? 4'b0001 : 4'b0000;
        @(negedge clk);
        saw  = saw | button_out[0] | rise_pulse[0] | fall_pulse[0];
        msaw = msaw | m_out[0] | m_rise[0] | m_fall[0];
      end
    end
    button_in = '0;
    repeat (20) begin
      @(negedge clk);
      saw = saw | button_out[0] | rise_pulse[0] | fall_pulse[0];
    end
    check("t2_ch0_quiet", 32'(saw), 32'h0);
    check("t2_model_quiet", 32'(msaw), 32'h0);

    // 3a: ch2 high for one sample too few
    saw = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      button_in = (e <= 15) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      saw = saw | button_out[2] | rise_pulse[2];
    end
    check("t3_15_quiet", 32'(saw), 32'h0);

    // 3b: ch2 high for exactly enough samples
    for (int e = 1; e <= 45; e++) begin
      button_in = (e <= 16) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (e == 17) check("t3_e17_out", 32'(button_out), 32'h0);
      if (e == 18) begin
        check("t3_e18_out", 32'(button_out), 32'h4);
        check("t3_e18_rise", 32'(rise_pulse), 32'h4);
      end
      if (e == 19) check("t3_e19_rise", 32'(rise_pulse), 32'h0);
      if (e == 34) check("t3_e34_fall", 32'(fall_pulse), 32'h4);
    end

    // 4: ch1 pressed 40 cycles then released
    for (int e = 1; e <= 80; e++) begin
      button_in = (e <= 40) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (e == 17) check("t4_e17_out", 32'(button_out), 32'h0);
      if (e == 18) check("t4_e18_rise", 32'({button_out, rise_pulse}), 32'h22);
      if (e == 57) check("t4_e57_out", 32'(button_out), 32'h2);
      if (e == 58) begin
        check("t4_e58_out", 32'(button_out), 32'h0);
        check("t4_e58_fall", 32'(fall_pulse), 32'h2);
        check("t4_model_e58", 32'(m_fall), 32'h2);
      end
      if (e == 59) check("t4_e59_fall", 32'(fall_pulse), 32'h0);
    end

    // 5: ch0 and ch3 pressed together, ch3 glitches low at edge 10
    for (int e = 1; e <= 45; e++) begin
      button_in = (e == 10) ? 4'b0001 : 4'b1001;
      @(negedge clk);
      if (e == 18) check("t5_e18", 32'({button_out, rise_pulse}), 32'h11);
      if (e == 27) check("t5_e27_out", 32'(button_out), 32'h1);
      if (e == 28) check("t5_e28", 32'({button_out, rise_pulse}), 32'h98);
    end
    button_in = '0;
    repeat (25) @(negedge clk);

`ifdef LONG_PRESS_EN
    // 6: long press on ch1
    for (int e = 1; e <= 140; e++) begin
      button_in = (e <= 100) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (e == 18) check("t6_e18_out", 32'(button_out), 32'h2);
      if (e == 81) check("t6_e81_long", 32'(long_press), 32'h0);
      if (e == 82) begin
        check("t6_e82_long", 32'(long_press), 32'h2);
        check("t6_model_e82", 32'(m_long), 32'h2);
      end
      if (e == 117) check("t6_e117_long", 32'(long_press), 32'h2);
      if (e == 118) check("t6_e118", 32'({button_out, long_press}), 32'h00);
    end
`endif

    // Randomized bouncing with occasional short resets
    lvl = '0;
    rst_left = 0;
    for (int ch = 0; ch < N_CH; ch++) rem[ch] = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = 1'($urandom_range(0, 1));
          rem[ch] = (($urandom_range(0, 3) == 0) ? $urandom_range(17, 90) : $urandom_range(1, 24));
        end
        rem[ch]--;
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      button_in = lvl;
      @(negedge clk);
    end
    reset = 1'b0;
    button_in = '0;
    repeat (25) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Multi-channel, parametrised push-button debouncer for the board's user-input path. It sits between the raw FPGA button pins and the control FSMs. Per channel it provides:
- a metastability synchroniser,
- a stability counter,
- a filtered level,
- one-cycle press and release strobes, so downstream logic needs no edge detectors.

The channel count, filter time and synchroniser depth are all parameters.

Parameters:
- N_CH, 4, number of independent button channels.
- STABLE_CYCLES, 1000000, consecutive synchronised samples at a new level needed before the output changes; 10 ms at 100 MHz; legal range is 2 or more.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; legal range is 2 or more.
- HOLD_CYCLES, 100000000, long-press threshold in cycles; used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- button_in  in  N_CH  raw asynchronous button levels, one bit per channel.
- button_out  out  N_CH  debounced level per channel.
- rise_pulse  out  N_CH  one-cycle strobe when button_out goes 0 to 1.
- fall_pulse  out  N_CH  one-cycle strobe when button_out goes 1 to 0.
- long_press  out  N_CH  long-hold level; present only with LONG_PRESS_EN.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: it is sampled on the rising clk edge while reset=1.
- Reset clears to 0: every synchroniser flop, every counter, button_out, rise_pulse, fall_pulse and long_press.
- Channels are fully independent. There is no shared state and no arbitration, and any number of channels may update in the same cycle.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel; sync_q is the last stage.
- Stability counter, per channel, width $clog2(STABLE_CYCLES). Each edge:
  - if sync_q == button_out, then cnt <= 0;
  - else if cnt == STABLE_CYCLES-1, then button_out <= sync_q and cnt <= 0 (this is the update);
  - else cnt <= cnt+1.
- Glitch filtering: any sample of sync_q equal to the current output restarts the count. Bounces shorter than STABLE_CYCLES samples never reach button_out.
- Latency: a clean input change first sampled at edge 1 updates button_out at edge SYNC_STAGES+STABLE_CYCLES, exactly.
- The input must be sampled at the new level on STABLE_CYCLES consecutive edges. One fewer produces no change.
- Strobes:
  - rise_pulse[i] is registered alongside an update to 1, so it is high exactly during the first cycle button_out[i] reads 1.
  - fall_pulse[i] behaves the same way for an update to 0.
  - Both are 0 in all other cycles and are never high together.
- Reset mid-operation: partial counts are discarded. If the button is held through reset, then after release button_out rises SYNC_STAGES+STABLE_CYCLES edges later and rise_pulse fires, because the reset level is 0.
- An elaboration-time check fails if STABLE_CYCLES<2 or SYNC_STAGES<2.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - Each channel has a hold counter that clears while button_out[i]=0 and counts while button_out[i]=1, saturating at HOLD_CYCLES.
  - long_press[i] asserts on the edge where the counter reaches HOLD_CYCLES, which is HOLD_CYCLES edges after button_out rises.
  - It stays high until the same edge that button_out[i] falls, and is cleared by reset.
- Undefined: the long_press port and the hold counters are absent, and all other behaviour is identical.

Test Plan:
All scenarios use N_CH=4, SYNC_STAGES=2, STABLE_CYCLES=16, HOLD_CYCLES=64, clk period 10 ns.
1. Hold reset=1 for 3 edges with button_in=4'b1111 -> every output is 0 during reset and on the first edge after release. button_out becomes 4'b1111 at edge 18 after release, with rise_pulse=4'b1111 for exactly one cycle.
2. Drive ch0 as 10 repetitions of 5 cycles high then 5 cycles low -> button_out[0]=0 throughout, and rise_pulse[0] and fall_pulse[0] never assert.
3. Boundary on ch2:
   - 15 cycles high then low -> no change.
   - 16 cycles high -> button_out[2]=1 at edge 18 counted from the first high sample, with rise_pulse[2] high that cycle only.
4. Press ch1 for 40 cycles, then release -> button_out[1] rises at edge 18, and falls 18 edges after the first low sample, with fall_pulse[1] high for one cycle.
5. Press ch0 and ch3 on the same edge, with ch3 bouncing low for 1 cycle at edge 10 -> ch0 updates at edge 18. ch3's count restarts, so it updates later, and ch0 is unaffected.
6. With LONG_PRESS_EN, hold ch1 for 100 cycles -> button_out[1] rises at edge 18, long_press[1] rises at edge 82, and long_press[1] falls on the same edge as button_out[1] after release.
